rtc_responder: RTL and testbench
================================

Name: rtc_responder

Overview:
- Synthesizable stand-in for the external RTC chip, sitting on the device side of the multiplexed AD/CS/RD/WR/IRQ bus.
- Decodes address and data bus cycles, holds a BCD time register file and keeps time from a clock-cycle prescaler.
- Drives read data onto the shared bus and raises an interrupt once per second.
- Used for on-FPGA loopback and bench verification of the PicoBlaze RTC port path.

Parameters:
- TICK_CYCLES, 100000000: clk cycles per one-second tick. Minimum 4; benches use a small value.
- SYNC_STAGES, 2: flip-flop stages on AD, CS, RD and WR. Fixed at 2 and documented for latency.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- AD  input  1  0 = address cycle, 1 = data cycle; asynchronous to clk
- CS  input  1  chip select, active-low
- RD  input  1  read strobe, active-low
- WR  input  1  write strobe, active-low
- IRQ  output  1  interrupt, active-low, registered
- bus  inout  8  multiplexed address/data; driven only during reads, otherwise high-Z

Behaviour:
- Reset (rst high at a clk edge):
  - sec=00, min=00, hour=00, day=01, month=01, year=00 (all BCD).
  - ctrl=0x00, status=0x00, addr latch=0x00, prescaler=0, tick pending=0.
  - IRQ=1, bus high-Z, synchronizers reset to the idle value 1.
  - Reset mid-cycle aborts the bus cycle; no write is committed.
- Synchronization and strobe detection:
  - AD, CS, RD and WR pass through a 2-FF synchronizer.
  - All decoding uses the synchronized versions, named s_*.
  - WR rise = s_WR 0->1 while s_CS=0. RD fall = s_RD 1->0 while s_CS=0 and s_AD=1.
- Bus cycle states: IDLE, ADDR_WR, DATA_WR, DATA_RD.
  - IDLE -> ADDR_WR when s_CS=0, s_WR=0, s_AD=0.
  - IDLE -> DATA_WR when s_CS=0, s_WR=0, s_AD=1.
  - IDLE -> DATA_RD when s_CS=0, s_RD=0, s_AD=1.
  - ADDR_WR: on WR rise, latch bus into addr, return to IDLE.
  - DATA_WR: on WR rise, write bus to register[addr], return to IDLE. Commit lands 3 clk after the raw WR rise.
  - DATA_RD: at RD fall, capture register[addr] into rd_snap. Bus drive enable registers one cycle later, so the bus is driven 3 clk after the raw RD fall. Drive is released 3 clk after the raw RD rise or CS rise, then return to IDLE.
  - s_CS rising in any state returns to IDLE with no commit.
  - s_RD=0 and s_WR=0 together is illegal: stay or return to IDLE, never drive the bus.
  - Bus data is sampled from the synchronized-edge cycle. The initiator must hold bus stable at least 4 clk past the WR rise.
- Register map (addr):
  - 0x00 ctrl, R/W. bit0 = STOP (prescaler halts), bit1 = IRQ enable. Other bits read 0.
  - 0x01 status, R. bit0 = tick flag. Any write to 0x01 clears the flag and releases IRQ.
  - 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year; all R/W.
  - Unmapped addresses: reads return 0x00, writes are ignored.
- Writes to 0x21..0x26 store the byte unchecked and clear the prescaler to 0.
- Timekeeping:
  - Prescaler counts 0..TICK_CYCLES-1 while STOP=0 and holds while STOP=1.
  - Wrap of the prescaler produces a one-cycle tick.
  - If a tick coincides with a commit to 0x21..0x26, the tick is deferred one cycle via the pending flag.
- Tick actions:
  - Set status bit0.
  - Increment the BCD chain: sec 00-59 -> min 00-59 -> hour 00-23 -> day 01-last -> month 01-12 -> year 00-99 (year wraps to 00).
  - Digit rule: a low nibble >=9 goes to 0 and carries into the high nibble. Any field >= its maximum (including invalid BCD) wraps to its minimum and carries.
  - last day = 31, 30 for months 04/06/09/11, and 28 for month 02, or 29 when the year is leap.
  - Leap year: tens even and units in {0,4,8}, or tens odd and units in {2,6}.
- IRQ = ~(status bit0 & ctrl bit1), registered one cycle after the status or ctrl change.
- A clear (write to 0x01) and a tick in the same cycle: the tick wins and the flag stays set.

Test Plan:
- Reset, then read 0x21..0x26 -> 00,00,00,01,01,00; bus high-Z outside reads; IRQ=1.
- Address cycle 0x23, data write 0x15, read back -> 0x15. Bus stays Z until 3 clk after the RD fall and returns to Z 3 clk after the RD rise.
- With TICK_CYCLES=8, preload 23:59:59 on 28/02/23 and run one tick -> 00:00:00, 01/03/23. Repeat with year 24 -> 29/02/24.
- Preload 31/12/99 23:59:59 and tick -> 01/01/00 00:00:00. Preload sec=0x5A and tick -> sec=00, min incremented.
- ctrl=0x02, wait one tick -> IRQ=0 and status=0x01. Write 0x01 -> IRQ=1 within 2 clk. With a clear and a tick in the same cycle, IRQ stays 0.
- ctrl=0x01 for 3×TICK_CYCLES -> time unchanged. Read of unmapped 0x7F -> 0x00. Raise CS mid-write -> no register change.

Source files
------------

// File: rtl/rtc_responder_if.sv
// -----------------------------------------------------------------------------
// rtc_responder_if
// Control strobes and interrupt line of the multiplexed RTC bus. The 8-bit
// AD/data bus itself is a bidirectional net and stays a plain inout port on
// the responder.
//   AD   0 = address cycle, 1 = data cycle (asynchronous to clk)
//   CS   chip select, active-low
//   RD   read strobe, active-low
//   WR   write strobe, active-low
//   IRQ  interrupt, active-low
// Modports:
//   master - bus initiator (drives AD/CS/RD/WR, observes IRQ)
//   slave  - RTC device side (observes AD/CS/RD/WR, drives IRQ)
// -----------------------------------------------------------------------------
interface rtc_responder_if;
    logic AD;
    logic CS;
    logic RD;
    logic WR;
    logic IRQ;

    modport master (
        output AD,
        output CS,
        output RD,
        output WR,
        input  IRQ
    );

    modport slave (
        input  AD,
        input  CS,
        input  RD,
        input  WR,
        output IRQ
    );
endinterface

// File: rtl/rtc_responder.sv
// -----------------------------------------------------------------------------
// rtc_responder
// Device-side model of the external RTC chip on the multiplexed AD/CS/RD/WR/IRQ
// bus. Decodes address and data cycles, holds a BCD time register file that
// advances once per TICK_CYCLES clocks, drives read data onto the shared bus
// and raises an active-low interrupt on every one-second tick.
//
// Parameters:
//   TICK_CYCLES  clk cycles per one-second tick (>= 4)
//   SYNC_STAGES  synchronizer depth on AD/CS/RD/WR (fixed at 2)
//
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   rtc  slave modport: AD, CS, RD, WR in (async), IRQ out (registered)
//   bus  8-bit multiplexed address/data, driven only during reads
//
// Latency (raw strobe edge to effect): write commit, read drive on and
// read drive off all land on the third clk edge after the raw edge.
//
// Register map:
//   0x00 ctrl   bit0 STOP, bit1 IRQ enable
//   0x01 status bit0 tick flag (any write clears)
//   0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year (BCD)
// -----------------------------------------------------------------------------
module rtc_responder #(
    parameter int TICK_CYCLES = 100000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    rtc_responder_if.slave rtc,
    inout  wire  [7:0]     bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_WR = 2'd1,
        DATA_WR = 2'd2,
        DATA_RD = 2'd3
    } state_t;

    localparam int              PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_CYCLES - 1);

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h01;
    localparam logic [7:0] A_SEC    = 8'h21;
    localparam logic [7:0] A_MIN    = 8'h22;
    localparam logic [7:0] A_HOUR   = 8'h23;
    localparam logic [7:0] A_DAY    = 8'h24;
    localparam logic [7:0] A_MONTH  = 8'h25;
    localparam logic [7:0] A_YEAR   = 8'h26;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Returns {carry, next}. A field at or above its maximum (including
    // invalid BCD such as 0x5A) wraps to its minimum and carries.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] vmax,
                                           input logic [7:0] vmin);
        if (v >= vmax)
            return {1'b1, vmin};
        else if (v[3:0] >= 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'h0};
        else
            return {1'b0, v + 8'd1};
    endfunction

    // Two-digit year leap rule: a multiple of 4 in BCD terms.
    function automatic logic is_leap(input logic [7:0] yr);
        logic [3:0] u;
        u = yr[3:0];
        if (!yr[4])
            return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
        else
            return (u == 4'd2) || (u == 4'd6);
    endfunction

    function automatic logic [7:0] last_day(input logic [7:0] mon,
                                            input logic [7:0] yr);
        case (mon)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return is_leap(yr) ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers (idle value 1 on all four lines)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic s_AD, s_CS, s_RD, s_WR;
    logic wr_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            wr_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rtc.AD, rtc.CS, rtc.RD, rtc.WR};
            wr_prev_q <= s_WR;
        end
    end

    assign {s_AD, s_CS, s_RD, s_WR} = sync_q[SYNC_STAGES-1];

    logic wr_rise;
    logic both_low;
    assign wr_rise  = s_WR & ~wr_prev_q & ~s_CS;
    assign both_low = ~s_RD & ~s_WR;

    // ------------------------------------------------------------------
    // Bus cycle FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   addr_we;
    logic   wr_commit;
    logic   snap_we;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        addr_we   = 1'b0;
        wr_commit = 1'b0;
        snap_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s_CS && !both_low) begin
                    if (!s_WR) begin
                        state_d = s_AD ? DATA_WR : ADDR_WR;
                    end else if (!s_RD && s_AD) begin
                        // Entering a read is the synchronized RD fall:
                        // snapshot the addressed register now.
                        state_d = DATA_RD;
                        snap_we = 1'b1;
                    end
                end
            end
            ADDR_WR: begin
                if (s_CS || both_low) begin
                    state_d = IDLE;
                end else if (wr_rise) begin
                    addr_we = 1'b1;
                    state_d = IDLE;
                end
            end
            DATA_WR: begin
                if (s_CS || both_low) begin
                    state_d = IDLE;
                end else if (wr_rise) begin
                    wr_commit = 1'b1;
                    state_d   = IDLE;
                end
            end
            DATA_RD: begin
                if (s_CS || s_RD || !s_WR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file, prescaler and interrupt
    // ------------------------------------------------------------------
    logic [7:0]    wdata;
    logic [7:0]    addr_q;
    logic [1:0]    ctrl_q;
    logic          flag_q;
    logic [7:0]    sec_q, min_q, hour_q, day_q, month_q, year_q;
    logic [PW-1:0] presc_q;
    logic          pend_q;
    logic          irq_q;
    logic          drv_q;
    logic [7:0]    snap_q;

    // Bus data is taken straight from the pad in the commit cycle; the
    // initiator holds it stable well beyond the synchronizer delay.
    assign wdata = bus;

    logic time_wr;
    logic tick_raw;
    logic tick_eff;
    assign time_wr  = wr_commit && (addr_q >= A_SEC) && (addr_q <= A_YEAR);
    assign tick_raw = ~ctrl_q[0] && (presc_q == PRESC_LAST);
    // A tick colliding with a time write is held back one cycle.
    assign tick_eff = (tick_raw | pend_q) & ~time_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            pend_q <= (tick_raw | pend_q) & time_wr;
            if (time_wr)
                presc_q <= '0;
            else if (!ctrl_q[0])
                presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    // BCD carry chain
    logic [8:0] sec_inc, min_inc, hour_inc, day_inc, mon_inc, year_inc;
    logic       en_min, en_hour, en_day, en_mon, en_year;

    always_comb begin
        sec_inc  = bcd_inc(sec_q,   8'h59, 8'h00);
        min_inc  = bcd_inc(min_q,   8'h59, 8'h00);
        hour_inc = bcd_inc(hour_q,  8'h23, 8'h00);
        day_inc  = bcd_inc(day_q,   last_day(month_q, year_q), 8'h01);
        mon_inc  = bcd_inc(month_q, 8'h12, 8'h01);
        year_inc = bcd_inc(year_q,  8'h99, 8'h00);
        en_min   = sec_inc[8];
        en_hour  = en_min  & min_inc[8];
        en_day   = en_hour & hour_inc[8];
        en_mon   = en_day  & day_inc[8];
        en_year  = en_mon  & mon_inc[8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= 8'h00;
            day_q   <= 8'h01;
            month_q <= 8'h01;
            year_q  <= 8'h00;
        end else if (time_wr) begin
            case (addr_q)
                A_SEC:   sec_q   <= wdata;
                A_MIN:   min_q   <= wdata;
                A_HOUR:  hour_q  <= wdata;
                A_DAY:   day_q   <= wdata;
                A_MONTH: month_q <= wdata;
                default: year_q  <= wdata;
            endcase
        end else if (tick_eff) begin
            sec_q <= sec_inc[7:0];
            if (en_min)  min_q   <= min_inc[7:0];
            if (en_hour) hour_q  <= hour_inc[7:0];
            if (en_day)  day_q   <= day_inc[7:0];
            if (en_mon)  month_q <= mon_inc[7:0];
            if (en_year) year_q  <= year_inc[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 8'h00;
            ctrl_q <= 2'b00;
            flag_q <= 1'b0;
            irq_q  <= 1'b1;
            drv_q  <= 1'b0;
        end else begin
            if (addr_we)
                addr_q <= wdata;
            if (wr_commit && addr_q == A_CTRL)
                ctrl_q <= wdata[1:0];
            // Tick has priority over a clear in the same cycle.
            if (tick_eff)
                flag_q <= 1'b1;
            else if (wr_commit && addr_q == A_STATUS)
                flag_q <= 1'b0;
            irq_q <= ~(flag_q & ctrl_q[1]);
            drv_q <= (state_d == DATA_RD);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0] rd_data;

    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            A_CTRL:   rd_data = {6'b0, ctrl_q};
            A_STATUS: rd_data = {7'b0, flag_q};
            A_SEC:    rd_data = sec_q;
            A_MIN:    rd_data = min_q;
            A_HOUR:   rd_data = hour_q;
            A_DAY:    rd_data = day_q;
            A_MONTH:  rd_data = month_q;
            A_YEAR:   rd_data = year_q;
            default:  rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (snap_we) snap_q <= rd_data;
    end

    assign bus     = drv_q ? snap_q : 8'hzz;
    assign rtc.IRQ = irq_q;

endmodule

// File: tb/tb_rtc_responder.sv
// -----------------------------------------------------------------------------
// tb_rtc_responder
// Directed bench for rtc_responder with TICK_CYCLES = 8. The bench acts as the
// bus initiator; a pull-up on the bus makes a released bus read as 0xFF.
// -----------------------------------------------------------------------------
module tb_rtc_responder;

    localparam int TICK = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tb_data;
    logic       tb_en;
    wire  [7:0] bus;

    rtc_responder_if rif ();

    assign bus = tb_en ? tb_data : 8'hzz;
    pullup pu_bus (bus);

    rtc_responder #(
        .TICK_CYCLES(TICK),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rtc(rif),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full write cycle; commit lands 6 edges after the call, returns after 10.
    task automatic wr_cycle(input logic ad, input logic [7:0] d);
        rif.AD  = ad;
        tb_data = d;
        tb_en   = 1'b1;
        rif.CS  = 1'b0;
        rif.WR  = 1'b0;
        tick(3);
        rif.WR  = 1'b1;
        tick(4);
        rif.CS  = 1'b1;
        tb_en   = 1'b0;
        rif.AD  = 1'b1;
        tick(3);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        wr_cycle(1'b0, a);
        wr_cycle(1'b1, d);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        wr_cycle(1'b0, a);
        rif.AD = 1'b1;
        rif.CS = 1'b0;
        rif.RD = 1'b0;
        tick(4);
        d = bus;
        rif.RD = 1'b1;
        rif.CS = 1'b1;
        tick(4);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd_reg(a, d);
        check(tag, d, exp);
    endtask

    task automatic set_time(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                            input logic [7:0] dd, input logic [7:0] mo, input logic [7:0] y);
        wr_reg(8'h21, s);
        wr_reg(8'h22, m);
        wr_reg(8'h23, h);
        wr_reg(8'h24, dd);
        wr_reg(8'h25, mo);
        wr_reg(8'h26, y);
    endtask

    task automatic chk_time(input string nm, input logic [7:0] s, input logic [7:0] m,
                            input logic [7:0] h, input logic [7:0] dd, input logic [7:0] mo,
                            input logic [7:0] y);
        rd_chk($sformatf("%s_sec", nm),   8'h21, s);
        rd_chk($sformatf("%s_min", nm),   8'h22, m);
        rd_chk($sformatf("%s_hour", nm),  8'h23, h);
        rd_chk($sformatf("%s_day", nm),   8'h24, dd);
        rd_chk($sformatf("%s_month", nm), 8'h25, mo);
        rd_chk($sformatf("%s_year", nm),  8'h26, y);
    endtask

    // Starts with STOP set, prescaler at 0 and address latch at 0x00.
    // Runs the clock until the first tick shows on IRQ, then writes stopval
    // to ctrl before the second tick can occur.
    task automatic run_one_tick(input logic [7:0] stopval);
        logic seen;
        wr_cycle(1'b1, 8'h02);
        rif.AD  = 1'b1;
        tb_data = stopval;
        tb_en   = 1'b1;
        rif.CS  = 1'b0;
        rif.WR  = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (rif.IRQ == 1'b0) seen = 1'b1;
        end
        rif.WR = 1'b1;
        tick(4);
        rif.CS = 1'b1;
        tb_en  = 1'b0;
        tick(3);
        check("tick_irq_seen", {7'b0, seen}, 8'h01);
    endtask

    task automatic one_tick_case(input string nm,
                                 input logic [7:0] s,  input logic [7:0] m,  input logic [7:0] h,
                                 input logic [7:0] dd, input logic [7:0] mo, input logic [7:0] y,
                                 input logic [7:0] es, input logic [7:0] em, input logic [7:0] eh,
                                 input logic [7:0] ed, input logic [7:0] emo, input logic [7:0] ey);
        set_time(s, m, h, dd, mo, y);
        wr_reg(8'h01, 8'h00);
        wr_cycle(1'b0, 8'h00);
        run_one_tick(8'h01);
        chk_time(nm, es, em, eh, ed, emo, ey);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        rif.AD  = 1'b1;
        rif.CS  = 1'b1;
        rif.RD  = 1'b1;
        rif.WR  = 1'b1;
        tb_en   = 1'b0;
        tb_data = 8'h00;
        tick(4);
        rst = 1'b0;

        // Reset state; stop the prescaler before its first tick (addr=0x00).
        check("rst_irq", {7'b0, rif.IRQ}, 8'h01);
        check("rst_bus_z", bus, 8'hFF);
        wr_cycle(1'b1, 8'h01);
        chk_time("rst", 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
        rd_chk("rst_status", 8'h01, 8'h00);
        check("idle_bus_z", bus, 8'hFF);

        // ctrl keeps only bits 1:0
        wr_reg(8'h00, 8'hFD);
        rd_chk("ctrl_mask", 8'h00, 8'h01);

        // Write hour, then read with bus drive timing
        begin
            logic [7:0] b1, b2, b3, b4, b5;
            wr_reg(8'h23, 8'h15);
            wr_cycle(1'b0, 8'h23);
            rif.AD = 1'b1;
            rif.CS = 1'b0;
            rif.RD = 1'b0;
            tick(1); b1 = bus;
            tick(1); b2 = bus;
            tick(1); b3 = bus;
            tick(2);
            rif.RD = 1'b1;
            rif.CS = 1'b1;
            tick(2); b4 = bus;
            tick(1); b5 = bus;
            tick(2);
            check("rd_z_1clk", b1, 8'hFF);
            check("rd_z_2clk", b2, 8'hFF);
            check("rd_drive_3clk", b3, 8'h15);
            check("rd_hold_2clk", b4, 8'h15);
            check("rd_release_3clk", b5, 8'hFF);
        end

        // STOP holds time for 3 tick periods
        wr_reg(8'h21, 8'h30);
        tick(3 * TICK);
        rd_chk("stop_sec", 8'h21, 8'h30);
        rd_chk("stop_status", 8'h01, 8'h00);

        // Unmapped read
        wr_reg(8'h7F, 8'h55);
        rd_chk("unmapped", 8'h7F, 8'h00);

        // CS raised mid-write: no commit to min
        wr_cycle(1'b0, 8'h22);
        rif.AD  = 1'b1;
        tb_data = 8'h44;
        tb_en   = 1'b1;
        rif.CS  = 1'b0;
        rif.WR  = 1'b0;
        tick(3);
        rif.CS = 1'b1;
        tick(3);
        rif.WR = 1'b1;
        tick(4);
        tb_en = 1'b0;
        tick(3);
        rd_chk("cs_abort_min", 8'h22, 8'h00);

        // Calendar rollovers
        one_tick_case("feb23", 8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h23,
                               8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h23);
        one_tick_case("feb24", 8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h24,
                               8'h00, 8'h00, 8'h00, 8'h29, 8'h02, 8'h24);
        one_tick_case("ny99",  8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99,
                               8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
        one_tick_case("sec5a", 8'h5A, 8'h10, 8'h05, 8'h15, 8'h06, 8'h10,
                               8'h00, 8'h11, 8'h05, 8'h15, 8'h06, 8'h10);

        // IRQ raise and clear
        wr_reg(8'h21, 8'h00);
        wr_reg(8'h01, 8'h00);
        wr_cycle(1'b0, 8'h00);
        run_one_tick(8'h03);
        check("irq_low", {7'b0, rif.IRQ}, 8'h00);
        rd_chk("irq_status", 8'h01, 8'h01);
        wr_cycle(1'b0, 8'h01);
        rif.AD  = 1'b1;
        tb_data = 8'h00;
        tb_en   = 1'b1;
        rif.CS  = 1'b0;
        rif.WR  = 1'b0;
        tick(3);
        rif.WR = 1'b1;
        tick(2);
        check("irq_before_clear", {7'b0, rif.IRQ}, 8'h00);
        tick(2);
        check("irq_cleared", {7'b0, rif.IRQ}, 8'h01);
        tick(2);
        rif.CS = 1'b1;
        tb_en  = 1'b0;
        tick(3);
        rd_chk("clr_status", 8'h01, 8'h00);

        // Clear colliding with a tick: flag must stay set.
        // ctrl=0x02 commits at edge C; ticks land at C+8k; the clear
        // sequence below commits exactly at C+24.
        wr_reg(8'h21, 8'h00);
        wr_reg(8'h01, 8'h00);
        wr_cycle(1'b0, 8'h00);
        wr_cycle(1'b1, 8'h02);
        wr_cycle(1'b0, 8'h01);
        tick(4);
        wr_cycle(1'b1, 8'h00);
        check("clr_tick_irq", {7'b0, rif.IRQ}, 8'h00);
        tick(1);
        check("clr_tick_irq2", {7'b0, rif.IRQ}, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
